hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Producer-side companion to the EX-stage bypass muxing in the 5-stage RV32I pipeline.
- Detects hazards that forwarding cannot resolve:
  - load-use dependencies;
  - variable-latency data-memory waits;
  - taken-branch redirects.
- Drives per-stage stall, bubble and flush controls.
- Tracks memory-wait state, a wait timeout and a stall-cycle performance counter.

Parameters:
- STALL_CNT_W, 16, width of saturating stall-cycle counter.
- MEM_TIMEOUT, 0, max MEM_WAIT cycles before timeout flag; 0 disables timeout.
- WAIT_CNT_W, 8, width of memory-wait cycle counter (must hold MEM_TIMEOUT).

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- id_rs1_i  input  5  rs1 index of instruction in ID.
- id_rs2_i  input  5  rs2 index of instruction in ID.
- id_rs1_used_i  input  1  ID instruction reads rs1.
- id_rs2_used_i  input  1  ID instruction reads rs2.
- ex_rd_i  input  5  rd of instruction in EX.
- ex_is_load_i  input  1  EX instruction is a valid load.
- ex_branch_taken_i  input  1  EX resolves a taken branch/jump.
- mem_req_i  input  1  MEM instruction issues a data-memory access this cycle.
- mem_rsp_valid_i  input  1  data memory completes the outstanding access.
- stall_if_o  output  1  hold PC and IF/ID.
- stall_id_o  output  1  hold ID/EX input side (ID instruction).
- stall_ex_o  output  1  hold EX/MEM.
- stall_mem_o  output  1  hold MEM/WB input.
- bubble_ex_o  output  1  load NOP into ID/EX.
- bubble_wb_o  output  1  load NOP into MEM/WB.
- flush_if_id_o  output  1  squash IF/ID.
- flush_id_ex_o  output  1  squash ID/EX.
- mem_timeout_o  output  1  sticky memory-timeout flag.
- stall_cycles_o  output  STALL_CNT_W  saturating count of cycles with stall_if_o high.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=RUN; wait_cnt=0; stall_cycles_o=0; mem_timeout_o=0.
  - All stall/bubble/flush outputs forced 0 while rst_n is low.
- FSM states: RUN, MEM_WAIT.
  - RUN -> MEM_WAIT when mem_req_i && !mem_rsp_valid_i.
  - MEM_WAIT -> RUN when mem_rsp_valid_i.
  - In MEM_WAIT, mem_req_i is ignored; the request is held by the memory interface.
- freeze (combinational):
  - RUN: mem_req_i && !mem_rsp_valid_i.
  - MEM_WAIT: !mem_rsp_valid_i.
  - Zero-wait response (req and rsp in the same RUN cycle): no freeze, no state change.
- load_use (combinational) = ex_is_load_i && ex_rd_i!=0 && ((id_rs1_used_i && id_rs1_i==ex_rd_i) || (id_rs2_used_i && id_rs2_i==ex_rd_i)). x0 never causes a hazard.
- Output priority 1, freeze:
  - stall_if/id/ex/mem=1, bubble_wb=1.
  - flush_*=0, bubble_ex=0.
  - A taken branch in EX stays frozen in EX, so its flush happens on the first unfrozen cycle.
- Output priority 2, ex_branch_taken_i:
  - flush_if_id=1, flush_id_ex=1; no stalls.
  - Overrides load_use, because the dependent instruction is squashed.
- Output priority 3, load_use:
  - stall_if=1, stall_id=1, bubble_ex=1; others 0.
  - Exactly one bubble per load-use; the next cycle the load is in MEM and the WB bypass covers it.
- Otherwise all control outputs are 0.
- All control outputs are combinational, same-cycle.
- wait_cnt:
  - Cleared on entry to MEM_WAIT (set to 1 on the RUN->MEM_WAIT cycle).
  - Increments each MEM_WAIT cycle without response, saturating.
  - Cleared on return to RUN.
- Timeout: if MEM_TIMEOUT!=0 and wait_cnt reaches MEM_TIMEOUT, mem_timeout_o is set on the next edge and stays set until reset. The FSM keeps waiting.
- stall_cycles_o increments on each edge where stall_if_o was 1; it saturates at all-ones and never wraps.

Decomposition:
- Shared constants package gets:
  - hz_state_e enum {HZ_RUN, HZ_MEM_WAIT};
  - REG_X0 = 5'd0 constant.
- Sub-module sat_counter (parameter W; inc, clr, q) serves both wait_cnt and stall_cycles_o.

Test Plan:
- Reset mid-MEM_WAIT: drop rst_n during wait -> all outputs 0 immediately, state RUN, counters 0.
- Load-use: ex_is_load=1, ex_rd=5, id_rs2=5 with rs2 used, no memory access -> stall_if=stall_id=bubble_ex=1 for exactly one cycle; stall_cycles_o=1.
- x0 and unused operand:
  - ex_rd=0 with id_rs1=0 -> no stall.
  - ex_rd=7 with id_rs1=7 but rs1_used=0 -> no stall.
- Memory wait: mem_req=1, rsp after 3 cycles:
  - freeze outputs high for 3 cycles, low in the rsp cycle;
  - stall_cycles_o +3;
  - zero-wait request -> no stall.
- Branch vs hazards:
  - branch_taken with load_use in the same cycle -> flush_if_id=flush_id_ex=1, no stall.
  - branch_taken during freeze -> no flush until the rsp cycle, then flush.
- Timeout: MEM_TIMEOUT=4, no rsp for 6 cycles -> mem_timeout_o rises after the 4th wait cycle and remains 1 after rsp; stall_cycles_o saturates at 16'hFFFF under a long forced stall.

Source files
------------

// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// Holds the FSM state encoding and the register-match helper used for load-use detection.
package hazard_stall_unit_pkg;

    typedef enum logic [0:0] {
        HZ_RUN,
        HZ_MEM_WAIT
    } hz_state_e;

    localparam logic [4:0] REG_X0 = 5'd0;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] src, input logic used,
                                       input logic [4:0] rd);
        return used && (rd != REG_X0) && (src == rd);
    endfunction

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-low reset.
// Shared by the memory-wait counter and the stall-cycle performance counter.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] MAX_VAL = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != MAX_VAL)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Hazard and stall controller for the 5-stage RV32I pipeline: resolves load-use,
// data-memory wait and taken-branch hazards into per-stage stall/bubble/flush controls.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int STALL_CNT_W = 16,
    parameter int MEM_TIMEOUT = 0,
    parameter int WAIT_CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4:0]             id_rs1_i,
    input  logic [4:0]             id_rs2_i,
    input  logic                   id_rs1_used_i,
    input  logic                   id_rs2_used_i,
    input  logic [4:0]             ex_rd_i,
    input  logic                   ex_is_load_i,
    input  logic                   ex_branch_taken_i,
    input  logic                   mem_req_i,
    input  logic                   mem_rsp_valid_i,
    output logic                   stall_if_o,
    output logic                   stall_id_o,
    output logic                   stall_ex_o,
    output logic                   stall_mem_o,
    output logic                   bubble_ex_o,
    output logic                   bubble_wb_o,
    output logic                   flush_if_id_o,
    output logic                   flush_id_ex_o,
    output logic                   mem_timeout_o,
    output logic [STALL_CNT_W-1:0] stall_cycles_o
);

    localparam bit                    TIMEOUT_EN  = (MEM_TIMEOUT != 0);
    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_VAL = WAIT_CNT_W'(MEM_TIMEOUT);

    hz_state_e             state;
    hz_state_e             next_state;
    logic                  freeze;
    logic                  load_use;
    logic                  wait_clr;
    logic [WAIT_CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HZ_RUN;
        end else begin
            state <= next_state;
        end
    end

    // A request answered in the same RUN cycle is zero-wait and never freezes the pipe.
    always_comb begin
        next_state = state;
        freeze     = 1'b0;
        case (state)
            HZ_RUN: begin
                if (mem_req_i && !mem_rsp_valid_i) begin
                    freeze     = 1'b1;
                    next_state = HZ_MEM_WAIT;
                end
            end
            HZ_MEM_WAIT: begin
                if (mem_rsp_valid_i) begin
                    next_state = HZ_RUN;
                end else begin
                    freeze = 1'b1;
                end
            end
            default: next_state = HZ_RUN;
        endcase
    end

    assign load_use = ex_is_load_i &&
                      (reg_match(id_rs1_i, id_rs1_used_i, ex_rd_i) ||
                       reg_match(id_rs2_i, id_rs2_used_i, ex_rd_i));

    // Freeze beats branch: a frozen branch keeps its redirect until the pipe moves again.
    always_comb begin
        stall_if_o    = 1'b0;
        stall_id_o    = 1'b0;
        stall_ex_o    = 1'b0;
        stall_mem_o   = 1'b0;
        bubble_ex_o   = 1'b0;
        bubble_wb_o   = 1'b0;
        flush_if_id_o = 1'b0;
        flush_id_ex_o = 1'b0;
        if (rst_n) begin
            if (freeze) begin
                stall_if_o  = 1'b1;
                stall_id_o  = 1'b1;
                stall_ex_o  = 1'b1;
                stall_mem_o = 1'b1;
                bubble_wb_o = 1'b1;
            end else if (ex_branch_taken_i) begin
                flush_if_id_o = 1'b1;
                flush_id_ex_o = 1'b1;
            end else if (load_use) begin
                stall_if_o  = 1'b1;
                stall_id_o  = 1'b1;
                bubble_ex_o = 1'b1;
            end
        end
    end

    assign wait_clr = (state == HZ_MEM_WAIT) && mem_rsp_valid_i;

    sat_counter #(.W(WAIT_CNT_W)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (freeze),
        .clr   (wait_clr),
        .q     (wait_cnt)
    );

    sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_if_o),
        .clr   (1'b0),
        .q     (stall_cycles_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_timeout_o <= 1'b0;
        end else if (TIMEOUT_EN && (wait_cnt == TIMEOUT_VAL)) begin
            mem_timeout_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: a rule-level reference model predicts each
// cycle's outputs into a queue; a negedge monitor pops and compares against the DUT.
module tb_hazard_stall_unit;

    localparam int TIMEOUT = 4;
    localparam int CNT_MAX = 65535;
    localparam int WC_MAX  = 255;

    typedef struct packed {
        logic [7:0]  ctl;
        logic        tmo;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic        id_rs1_used = 1'b0, id_rs2_used = 1'b0;
    logic        ex_is_load = 1'b0, ex_branch_taken = 1'b0;
    logic        mem_req = 1'b0, mem_rsp_valid = 1'b0;
    logic        stall_if, stall_id, stall_ex, stall_mem;
    logic        bubble_ex, bubble_wb, flush_if_id, flush_id_ex;
    logic        mem_timeout;
    logic [15:0] stall_cycles;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state, described in terms of the behaviour rules.
    bit   mWaiting = 0;
    int   mWaitCount = 0;
    int   mStallCount = 0;
    bit   mTimeout = 0;

    hazard_stall_unit #(
        .STALL_CNT_W (16),
        .MEM_TIMEOUT (TIMEOUT),
        .WAIT_CNT_W  (8)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .id_rs1_i          (id_rs1),
        .id_rs2_i          (id_rs2),
        .id_rs1_used_i     (id_rs1_used),
        .id_rs2_used_i     (id_rs2_used),
        .ex_rd_i           (ex_rd),
        .ex_is_load_i      (ex_is_load),
        .ex_branch_taken_i (ex_branch_taken),
        .mem_req_i         (mem_req),
        .mem_rsp_valid_i   (mem_rsp_valid),
        .stall_if_o        (stall_if),
        .stall_id_o        (stall_id),
        .stall_ex_o        (stall_ex),
        .stall_mem_o       (stall_mem),
        .bubble_ex_o       (bubble_ex),
        .bubble_wb_o       (bubble_wb),
        .flush_if_id_o     (flush_if_id),
        .flush_id_ex_o     (flush_id_ex),
        .mem_timeout_o     (mem_timeout),
        .stall_cycles_o    (stall_cycles)
    );

    always #5 clk = ~clk;

    // One call = one clock cycle of stimulus; the expected response is queued for the monitor.
    task automatic applyStimulus(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic [4:0] rd,
                                 input logic ld, input logic br, input logic req,
                                 input logic rsp);
        exp_t e;
        bit   frozen, hazard;
        @(posedge clk);
        #1;
        rst_n = r; id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
        ex_rd = rd; ex_is_load = ld; ex_branch_taken = br; mem_req = req; mem_rsp_valid = rsp;
        if (!r) begin
            mWaiting = 0; mWaitCount = 0; mStallCount = 0; mTimeout = 0;
            e.ctl = 8'b0; e.tmo = 1'b0; e.cnt = 16'd0;
            expQ.push_back(e);
            return;
        end
        frozen = mWaiting ? !rsp : (req && !rsp);
        hazard = ld && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        // ctl = {stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_wb, flush_if_id, flush_id_ex}
        if (frozen)      e.ctl = 8'b1111_0100;
        else if (br)     e.ctl = 8'b0000_0011;
        else if (hazard) e.ctl = 8'b1100_1000;
        else             e.ctl = 8'b0000_0000;
        e.tmo = mTimeout;
        e.cnt = 16'(mStallCount);
        expQ.push_back(e);
        if (e.ctl[7] && mStallCount < CNT_MAX) mStallCount++;
        if (mWaitCount == TIMEOUT) mTimeout = 1;
        mWaitCount = frozen ? ((mWaitCount < WC_MAX) ? mWaitCount + 1 : WC_MAX) : 0;
        mWaiting = frozen;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("ctl", {24'b0, stall_if, stall_id, stall_ex, stall_mem,
                                bubble_ex, bubble_wb, flush_if_id, flush_id_ex}, {24'b0, e.ctl});
            checkOutput("mem_timeout", {31'b0, mem_timeout}, {31'b0, e.tmo});
            checkOutput("stall_cycles", {16'b0, stall_cycles}, {16'b0, e.cnt});
        end
    end

    initial begin
        $display("[TB] start");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // load-use on rs2, single bubble
        applyStimulus(1, 5'd1, 5'd5, 1, 1, 5'd5, 1, 0, 0, 0);
        idle(2);
        // x0 never hazards; unused operand never hazards
        applyStimulus(1, 5'd0, 5'd3, 1, 0, 5'd0, 1, 0, 0, 0);
        applyStimulus(1, 5'd7, 5'd2, 0, 1, 5'd7, 1, 0, 0, 0);
        idle(1);

        // memory wait, response after 3 frozen cycles, then a zero-wait access
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(1);

        // branch beats load-use; branch during freeze flushes only on the response cycle
        applyStimulus(1, 5'd9, 5'd0, 1, 0, 5'd9, 1, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        idle(1);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(1, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 2) == 0));
        end
        idle(1);

        // reset dropped mid-wait, with other hazards asserted
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 5'd4, 5'd4, 1, 1, 5'd4, 1, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // timeout: six wait cycles without response, then response; flag stays set
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);

        // long forced stall drives the performance counter into saturation
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 65600; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(3);

        for (int i = 0; i < 5 && expQ.size() > 0; i++) @(posedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
